// File: rtl/bus_arbiter_if.sv
// Bus-ownership interface between the requesting blocks (master) and bus_arbiter (slave).
// Carries requests/locks/pull-down mask in and the registered bus enables out.
interface bus_arbiter_if #(
    parameter int N = 4
);
    localparam int OW = $clog2(N);

    logic [N-1:0]  req;
    logic [N-1:0]  lock;
    logic [7:0]    pd_req;
    logic [N-1:0]  driver_enables;
    logic [7:0]    pull_down_enables;
    logic [OW-1:0] owner;
    logic          grant_valid;
    logic          err;

    // Handshake: req is level-sensitive and held by a requester until it no longer
    // needs the bus; the grant is indicated by driver_enables/grant_valid one cycle
    // after the arbiter decides, and a requester may only drive while its enable is high.
    modport master (
        output req,
        output lock,
        output pd_req,
        input  driver_enables,
        input  pull_down_enables,
        input  owner,
        input  grant_valid,
        input  err
    );

    modport slave (
        input  req,
        input  lock,
        input  pd_req,
        output driver_enables,
        output pull_down_enables,
        output owner,
        output grant_valid,
        output err
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin owner sequencer for the shared 8-bit bus with lock, forced release and turnaround.
// Optional sticky protocol checker enabled by defining BUS_ARBITER_PROTOCOL_CHECK_EN.
module bus_arbiter #(
    parameter int N          = 4,
    parameter int TURNAROUND = 1,
    parameter int MAX_HOLD   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bus_arbiter_if.slave         bus,
    output logic [1:0]           state_dbg,
    output logic [$clog2(N)-1:0] rr_ptr_dbg
);
    localparam int OW = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int TW = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    state_t        state_q, state_n;
    logic [OW-1:0] owner_q, owner_n;
    logic [OW-1:0] rr_ptr_q, rr_ptr_n;
    logic [HW-1:0] hold_q, hold_n;
    logic [TW-1:0] turn_q, turn_n;
    logic [N-1:0]  de_q, de_n;
    logic [7:0]    pd_q, pd_n;

    logic [N-1:0]  owner_oh;
    logic [OW-1:0] rr_next;
    logic          others;
    logic          hold_at_max;
    logic          keep;

    // First requester at or after start, wrapping; iterating downwards lets the
    // smallest offset win without a break.
    function automatic logic [OW-1:0] rr_pick(input logic [N-1:0] r, input logic [OW-1:0] start);
        logic [OW-1:0] win;
        int            idx;
        win = start;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(start) + k) % N;
            if (r[OW'(idx)]) win = OW'(idx);
        end
        return win;
    endfunction

    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_q] = 1'b1;
        rr_next           = (int'(owner_q) == N - 1) ? '0 : owner_q + 1'b1;
        others            = |(bus.req & ~owner_oh);
        hold_at_max       = (hold_q >= HW'(MAX_HOLD));
        keep              = bus.req[owner_q] &&
                            ((bus.lock[owner_q] && !(others && hold_at_max)) || !others);
    end

    // State register: all architectural state updates here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            hold_q   <= '0;
            turn_q   <= '0;
            de_q     <= '0;
            pd_q     <= 8'h00;
        end else begin
            state_q  <= state_n;
            owner_q  <= owner_n;
            rr_ptr_q <= rr_ptr_n;
            hold_q   <= hold_n;
            turn_q   <= turn_n;
            de_q     <= de_n;
            pd_q     <= pd_n;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n  = state_q;
        owner_n  = owner_q;
        rr_ptr_n = rr_ptr_q;
        hold_n   = hold_q;
        turn_n   = turn_q;
        case (state_q)
            S_IDLE: begin
                if (|bus.req) begin
                    state_n = S_GRANT;
                    owner_n = rr_pick(bus.req, rr_ptr_q);
                    hold_n  = HW'(1);
                end
            end
            S_GRANT: begin
                if (keep) begin
                    if (!hold_at_max) hold_n = hold_q + 1'b1;
                end else begin
                    rr_ptr_n = rr_next;
                    if (!others) begin
                        state_n = S_IDLE;
                    end else if (TURNAROUND > 0) begin
                        state_n = S_TURN;
                        turn_n  = TW'(TURNAROUND);
                    end else begin
                        // Zero turnaround: hand over directly, released owner scanned last.
                        owner_n = rr_pick(bus.req, rr_next);
                        hold_n  = HW'(1);
                    end
                end
            end
            S_TURN: begin
                if (turn_q == TW'(1)) begin
                    turn_n = '0;
                    if (|bus.req) begin
                        state_n = S_GRANT;
                        owner_n = rr_pick(bus.req, rr_ptr_q);
                        hold_n  = HW'(1);
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    turn_n = turn_q - 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered bus controls.
    always_comb begin
        de_n = '0;
        if (state_n == S_GRANT) de_n[owner_n] = 1'b1;
        pd_n = (state_n == S_TURN) ? 8'h00 : bus.pd_req;
    end

    assign bus.driver_enables    = de_q;
    assign bus.pull_down_enables = pd_q;
    assign bus.owner             = owner_q;
    assign bus.grant_valid       = (state_q == S_GRANT);
    assign state_dbg             = state_q;
    assign rr_ptr_dbg            = rr_ptr_q;

`ifdef BUS_ARBITER_PROTOCOL_CHECK_EN
    logic err_q;
    logic proto_viol;

    // A lock without its request is meaningless; flag it on any lane while granting.
    always_comb begin
        proto_viol = (state_q == S_GRANT) &&
                     ((bus.lock[owner_q] && !bus.req[owner_q]) || |(bus.lock & ~bus.req));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (proto_viol) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Sequences ownership of the shared 8-bit internal data bus between N driving blocks.
- Produces the registered one-hot driver_enables and the gated pull_down_enables consumed by the bus resolver.
- Round-robin arbitration, optional multi-cycle lock, forced release after a maximum hold time.
- Configurable dead (turnaround) cycles between different owners, so two drivers are never enabled in the same cycle.

Parameters:
- N, 4, number of requesters/drivers; N >= 2.
- TURNAROUND, 1, dead cycles (0..3) with no driver enabled between different owners.
- MAX_HOLD, 8, max consecutive grant cycles while another requester waits; >= 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- req  input  N  per-requester bus request; level-sensitive.
- lock  input  N  owner keeps bus while lock[owner] && req[owner]; ignored for non-owners.
- pd_req  input  8  requested pull-down bit mask.
- driver_enables  output  N  registered one-hot (or zero) driver enable to bus.
- pull_down_enables  output  8  registered pull-down enables to bus.
- owner  output  $clog2(N)  index of current owner; valid when grant_valid.
- grant_valid  output  1  high when driver_enables != 0.
- err  output  1  sticky protocol-error flag (see Optional Feature).

Behaviour:
- Clock/reset: single clock clk. rst_n is synchronous and active-low. It is sampled on the rising edge; when low, the next state is reset regardless of other inputs.
- Reset values: state=IDLE, driver_enables=0, pull_down_enables=0, owner=0, grant_valid=0, err=0, rr_ptr=0, hold_cnt=0, turn_cnt=0.
- States: IDLE, GRANT, TURN.
- Winner: the first i with req[i]=1 scanning rr_ptr, rr_ptr+1, ..., wrapping mod N.
- IDLE:
  - If req != 0: next state GRANT, owner=winner, driver_enables=onehot(winner), hold_cnt=1.
  - Latency req rise -> enable is exactly 1 cycle.
- GRANT, continue condition: req[owner] && ((lock[owner] && !(others && hold_cnt>=MAX_HOLD)) || !others), where others = |(req & ~onehot(owner)).
- GRANT, continue: stay; hold_cnt saturates at MAX_HOLD.
- GRANT, release: rr_ptr=(owner+1) mod N, then:
  - If others and TURNAROUND>0: TURN, turn_cnt=TURNAROUND.
  - If others and TURNAROUND=0: GRANT with the new winner in the next cycle (back-to-back), hold_cnt=1.
  - If no others: IDLE.
- Forced release: when others are waiting, lock is overridden once hold_cnt reaches MAX_HOLD.
- Sole requester: keeps the grant indefinitely; no turnaround, no forced release.
- TURN:
  - driver_enables=0 and grant_valid=0; turn_cnt decrements each cycle.
  - On the cycle turn_cnt==1, winner is evaluated on current req. If any req: GRANT. Else: IDLE.
  - Requests dropping during TURN are simply not granted.
- Winner scan after release starts at the updated rr_ptr, so the released owner has lowest priority.
- pull_down_enables: registered, next = pd_req when next state is IDLE or GRANT, 0 when next state is TURN.
- owner holds its last value in IDLE/TURN; grant_valid = (state==GRANT).
- Invariant: popcount(driver_enables) <= 1 every cycle. Different owners are separated by >= TURNAROUND zero cycles.

Optional Feature:
- Macro: BUS_ARBITER_PROTOCOL_CHECK_EN.
- Defined: err is set (sticky until reset) on a cycle in GRANT where either:
  - req[owner]=0 while lock[owner]=1, or
  - lock[i]=1 with req[i]=0 for any i.
- Not defined: err is tied to 0 and the check logic is absent.

Test Plan:
- Reset then req=4'b0100 -> cycle+1 driver_enables=0100, owner=2, grant_valid=1; pd_req=8'h81 -> pull_down_enables=8'h81 one cycle later.
- req=4'b0011 held, lock=0, TURNAROUND=1 -> grants alternate 0001, 0000, 0010, 0000, 0001...; never two bits set.
- req=4'b0011, lock[0]=1, MAX_HOLD=8 -> owner 0 for exactly 8 cycles, 1 dead cycle, then 0010.
- TURNAROUND=0, req=4'b1001 -> back-to-back 0001, 1000 with no zero cycle.
- rst_n low mid-GRANT with pd_req=8'hFF -> next cycle driver_enables=0, pull_down_enables=0, state IDLE, rr_ptr=0.
- With BUS_ARBITER_PROTOCOL_CHECK_EN: owner drops req while lock=1 -> err=1 next cycle and stays 1 until reset. Without the macro, err stays 0.
